// File: rtl/pixel_stream.sv
// pixel_stream: framed XOR-mask stage feeding a DEPTH-entry output FIFO, FSM IDLE/ARM/RUN/DRAIN.
// Optional feature macro PIXEL_STREAM_CSUM_EN adds a running checksum of popped pixels on csum.
module pixel_stream #(
  parameter int          PIX_W     = 8,
  parameter int          DEPTH     = 4,
  parameter int          FRAME_LEN = 64,
  parameter logic [31:0] MASK      = 32'hCC
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_out_valid,
  input  logic             pix_out_ready,
  output logic [1:0]       status,
  output logic [15:0]      pix_cnt,
  output logic             frame_done
`ifdef PIXEL_STREAM_CSUM_EN
  ,
  output logic [PIX_W-1:0] csum
`endif
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [PIX_W-1:0] MASK_W   = MASK[PIX_W-1:0];
  localparam logic [15:0]      LAST_CNT = 16'(FRAME_LEN - 1);
  localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [15:0]      r_pix_cnt;
  logic             r_frame_done;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_last;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign pix_in_ready  = (r_state == S_RUN) && en && !w_full;
  assign w_push        = pix_in_valid && pix_in_ready;
  assign pix_out_valid = !w_empty;
  assign w_pop         = pix_out_valid && pix_out_ready;
  assign pix_out       = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign w_last        = w_push && (r_pix_cnt == LAST_CNT);

  assign status     = r_state;
  assign pix_cnt    = r_pix_cnt;
  assign frame_done = r_frame_done;

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && en) w_state_nxt = S_ARM;
        else             w_state_nxt = S_IDLE;
      end
      S_ARM:   w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_last) w_state_nxt = S_DRAIN;
        else        w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (w_empty) w_state_nxt = S_IDLE;
        else         w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FIFO pointers; reset discards any buffered pixels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage; contents are masked by w_empty on the output, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= pix_in ^ MASK_W;
  end

  // Pixel counter: cleared in ARM, held through DRAIN and IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  r_pix_cnt <= 16'd0;
    else if (r_state == S_ARM)  r_pix_cnt <= 16'd0;
    else if (w_push)            r_pix_cnt <= r_pix_cnt + 16'd1;
    else                        r_pix_cnt <= r_pix_cnt;
  end

  // End-of-frame pulse, registered on the DRAIN-to-IDLE transition.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_frame_done <= 1'b0;
    else       r_frame_done <= (r_state == S_DRAIN) && w_empty;
  end

`ifdef PIXEL_STREAM_CSUM_EN
  logic [PIX_W-1:0] r_csum;

  // Running modulo-2^PIX_W sum of every pixel leaving the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 r_csum <= '0;
    else if (r_state == S_ARM) r_csum <= '0;
    else if (w_pop)            r_csum <= r_csum + pix_out;
    else                       r_csum <= r_csum;
  end

  assign csum = r_csum;
`endif

endmodule

// File: tb/tb_pixel_stream.sv
// Directed bench for pixel_stream: u_a (FRAME_LEN=4) for the basic frame, u_b (FRAME_LEN=8) for
// backpressure, enable, start-ignore and mid-frame reset scenarios.
module tb_pixel_stream;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic       start_a;
  logic       start_b;
  logic [7:0] pix_in;
  logic       pix_in_valid;
  logic       pix_out_ready;

  logic       a_rdy, a_vld, a_fd, b_rdy, b_vld, b_fd;
  logic [7:0] a_pix_out, b_pix_out;
  logic [1:0] a_status, b_status;
  logic [15:0] a_cnt, b_cnt;
`ifdef PIXEL_STREAM_CSUM_EN
  logic [7:0] a_csum, b_csum;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int a_fd_cnt = 0;
  int b_fd_cnt = 0;
  logic [7:0] a_q[$];

  always #5 clk = ~clk;

  pixel_stream #(.PIX_W(8), .DEPTH(4), .FRAME_LEN(4), .MASK(32'hCC)) u_a (
    .clk(clk), .rstn(rstn), .en(en), .start(start_a),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(a_rdy),
    .pix_out(a_pix_out), .pix_out_valid(a_vld), .pix_out_ready(pix_out_ready),
    .status(a_status), .pix_cnt(a_cnt), .frame_done(a_fd)
`ifdef PIXEL_STREAM_CSUM_EN
    , .csum(a_csum)
`endif
  );

  pixel_stream #(.PIX_W(8), .DEPTH(4), .FRAME_LEN(8), .MASK(32'hCC)) u_b (
    .clk(clk), .rstn(rstn), .en(en), .start(start_b),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(b_rdy),
    .pix_out(b_pix_out), .pix_out_valid(b_vld), .pix_out_ready(pix_out_ready),
    .status(b_status), .pix_cnt(b_cnt), .frame_done(b_fd)
`ifdef PIXEL_STREAM_CSUM_EN
    , .csum(b_csum)
`endif
  );

  // Mid-cycle monitor: records u_a output transfers and frame_done pulses of both instances.
  always @(negedge clk) begin
    if (a_vld && pix_out_ready) a_q.push_back(a_pix_out);
    if (a_fd) a_fd_cnt++;
    if (b_fd) b_fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_out [4];
    logic [7:0] exp_sum;
    int         fd_before;
    exp_out = '{8'hCC, 8'h33, 8'hC3, 8'h00};

    rstn = 1'b0; en = 1'b0; start_a = 1'b0; start_b = 1'b0;
    pix_in = 8'h00; pix_in_valid = 1'b0; pix_out_ready = 1'b0;
    step(); step();
    chk("rst_status", a_status, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_fd", a_fd, 0);
    chk("rst_out_valid", a_vld, 0);
    chk("rst_in_ready", a_rdy, 0);
    chk("rst_pix_out", a_pix_out, 0);
    rstn = 1'b1;
    step();
    chk("idle_after_rst", a_status, 0);

    // Basic frame on u_a: 00,FF,0F,CC -> CC,33,C3,00.
    en = 1'b1; pix_out_ready = 1'b1; start_a = 1'b1;
    step();
    chk("a_arm", a_status, 1);
    start_a = 1'b0;
    step();
    chk("a_run", a_status, 2);
    chk("a_cnt_clr", a_cnt, 0);
    chk("a_empty_run", a_vld, 0);
    pix_in_valid = 1'b1;
    pix_in = 8'h00; step();
    chk("a_latency_valid", a_vld, 1);
    chk("a_latency_data", a_pix_out, 8'hCC);
    pix_in = 8'hFF; step();
    pix_in = 8'h0F; step();
    pix_in = 8'hCC; step();
    chk("a_drain", a_status, 3);
    chk("a_cnt4", a_cnt, 4);
    pix_in_valid = 1'b0;
    for (int k = 0; k < 20 && a_status != 2'd0; k++) step();
    chk("a_back_idle", a_status, 0);
    chk("a_fd_high", a_fd, 1);
    step();
    chk("a_fd_low", a_fd, 0);
    chk("a_fd_count", a_fd_cnt, 1);
    chk("a_cnt_hold", a_cnt, 4);
    chk("a_out_count", a_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("a_out%0d", i), (i < a_q.size()) ? a_q[i] : 8'hxx, exp_out[i]);
`ifdef PIXEL_STREAM_CSUM_EN
    exp_sum = 8'h00;
    for (int i = 0; i < 4; i++) exp_sum = exp_sum + exp_out[i];
    chk("a_csum", a_csum, exp_sum);
`else
    exp_sum = 8'h00;
`endif

    // Backpressure on u_b: fill 4 entries, 5th waits until a pop frees space.
    pix_out_ready = 1'b0; start_b = 1'b1;
    step();
    start_b = 1'b0;
    step();
    chk("b_run", b_status, 2);
    pix_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_in = 8'(i + 1);
      chk($sformatf("b_ready%0d", i), b_rdy, 1);
      step();
    end
    chk("b_full_ready", b_rdy, 0);
    chk("b_full_cnt", b_cnt, 4);
    chk("b_head", b_pix_out, 8'hCD);
    pix_in = 8'h05;
    step();
    chk("b_stall_cnt", b_cnt, 4);
    pix_out_ready = 1'b1;
    step();
    chk("b_pop1_ready", b_rdy, 1);
    chk("b_pop1_data", b_pix_out, 8'hCE);
    step();
    chk("b_push5_cnt", b_cnt, 5);
    chk("b_pop2_data", b_pix_out, 8'hCF);
    pix_in_valid = 1'b0;
    step();
    chk("b_pop3_data", b_pix_out, 8'hC8);
    step();
    chk("b_pop4_data", b_pix_out, 8'hC9);
    step();
    chk("b_drained", b_vld, 0);

    // Enable low for 3 cycles: no input transfers, output keeps draining.
    pix_out_ready = 1'b0; pix_in_valid = 1'b1; pix_in = 8'h10;
    step();
    chk("b_en_pre_cnt", b_cnt, 6);
    en = 1'b0; pix_in = 8'h11; pix_out_ready = 1'b1;
    #1;
    chk("b_en_low_ready", b_rdy, 0);
    step();
    chk("b_en_drain", b_vld, 0);
    chk("b_en_cnt1", b_cnt, 6);
    step();
    chk("b_en_cnt2", b_cnt, 6);
    step();
    chk("b_en_cnt3", b_cnt, 6);
    en = 1'b1;
    #1;
    chk("b_en_high_ready", b_rdy, 1);
    pix_out_ready = 1'b0;
    step();
    chk("b_en_resume_cnt", b_cnt, 7);
    chk("b_en_resume_data", b_pix_out, 8'hDD);

    // Start pulses in RUN and DRAIN are ignored.
    pix_in_valid = 1'b0; start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_start_run_state", b_status, 2);
    chk("b_start_run_cnt", b_cnt, 7);
    pix_in_valid = 1'b1; pix_in = 8'h12;
    step();
    pix_in_valid = 1'b0;
    chk("b_drain", b_status, 3);
    chk("b_cnt8", b_cnt, 8);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_start_drain_state", b_status, 3);
    chk("b_start_drain_cnt", b_cnt, 8);
    pix_out_ready = 1'b1;
    for (int k = 0; k < 20 && b_status != 2'd0; k++) step();
    chk("b_idle", b_status, 0);
    chk("b_idle_cnt", b_cnt, 8);

    // Reset mid-frame with 3 entries buffered.
    step();
    pix_out_ready = 1'b0; start_b = 1'b1;
    step();
    start_b = 1'b0;
    step();
    chk("b_rst_run", b_status, 2);
    chk("b_rst_cnt_clr", b_cnt, 0);
    pix_in_valid = 1'b1;
    pix_in = 8'h20; step();
    pix_in = 8'h21; step();
    pix_in = 8'h22; step();
    pix_in_valid = 1'b0;
    chk("b_pre_rst_cnt", b_cnt, 3);
    chk("b_pre_rst_valid", b_vld, 1);
    fd_before = b_fd_cnt;
    #2;
    rstn = 1'b0;
    #1;
    chk("b_rst_valid", b_vld, 0);
    chk("b_rst_status", b_status, 0);
    chk("b_rst_pix_out", b_pix_out, 0);
    chk("b_rst_cnt", b_cnt, 0);
    step(); step();
    rstn = 1'b1;
    step(); step(); step();
    chk("b_post_rst_valid", b_vld, 0);
    chk("b_post_rst_status", b_status, 0);
    chk("b_no_fd", b_fd_cnt, fd_before);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
